// File: rtl/prog_load_pkg.sv
// Shared types and defaults for the serial program-load receiver.
// Parity framing is enabled by defining PROG_LOAD_PARITY_EN.
package prog_load_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/prog_load_rx_sync_bit.sv
// Single-bit multi-flop synchronizer with configurable reset value.
// Used once per asynchronous serial pin.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/prog_load_rx.sv
// Serial frame receiver feeding a load word to a downstream counter.
// Define PROG_LOAD_PARITY_EN to append an even-parity bit to each frame.
module prog_load_rx
  import prog_load_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_cs_n,
  input  logic              ser_clk,
  input  logic              ser_dat,
  output logic [DATA_W-1:0] load_value,
  output logic              load_valid,
  input  logic              load_ready,
  output logic              err_frame
);

`ifdef PROG_LOAD_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  logic cs_s, sclk_s, dat_s;
  logic cs_d, sclk_d, dat_d;
  logic cs_fall, cs_rise, sclk_rise;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser_cs_n),
    .q    (cs_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser_clk),
    .q    (sclk_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dat (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser_dat),
    .q    (dat_s)
  );

  // Strobes are registered; dat_d and cs_d stay aligned with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
      dat_d     <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      sclk_rise <= 1'b0;
    end else begin
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
      dat_d     <= dat_s;
      cs_fall   <= cs_d & ~cs_s;
      cs_rise   <= ~cs_d & cs_s;
      sclk_rise <= ~sclk_d & sclk_s;
    end
  end

  state_t                  state, state_n;
  logic [CNT_W-1:0]        bit_cnt, cnt_n;
  logic [FRAME_BITS-1:0]   shreg, sh_n;
  logic [DATA_W-1:0]       val_n;
  logic                    err_n;
  logic                    drop, drop_n;
  logic                    len_ok, par_ok, frame_ok;
  logic [DATA_W-1:0]       word;

  assign word   = shreg[FRAME_BITS-1 -: DATA_W];
  assign len_ok = (bit_cnt == CNT_W'(FRAME_BITS));
`ifdef PROG_LOAD_PARITY_EN
  assign par_ok = ~(^shreg);
`else
  assign par_ok = 1'b1;
`endif
  assign frame_ok = len_ok & par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      load_value <= '0;
      err_frame  <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      shreg      <= sh_n;
      load_value <= val_n;
      err_frame  <= err_n;
      drop       <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    val_n   = load_value;
    err_n   = 1'b0;
    drop_n  = drop;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sh_n    = '0;
        end else if (cs_rise && drop) begin
          err_n  = 1'b1;
          drop_n = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (frame_ok) begin
            val_n   = word;
            state_n = HOLD;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (sclk_rise && !cs_d) begin
          sh_n = {shreg[FRAME_BITS-2:0], dat_d};
          if (bit_cnt != {CNT_W{1'b1}}) begin
            cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (load_ready) begin
          state_n = IDLE;
          if (cs_fall) begin
            state_n = SHIFT;
            cnt_n   = '0;
            sh_n    = '0;
          end
        end else if (cs_fall) begin
          drop_n = 1'b1;
        end else if (cs_rise && drop) begin
          err_n  = 1'b1;
          drop_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign load_valid = (state == HOLD);

endmodule

// File: tb/tb_prog_load_rx.sv
// Directed bench for prog_load_rx: vector table plus corner sequences.
// Build with PROG_LOAD_PARITY_EN defined to exercise parity framing.
module tb_prog_load_rx;

  localparam int DW = 8;
  localparam int SS = 2;
`ifdef PROG_LOAD_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ser_cs_n = 1'b1;
  logic          ser_clk = 1'b0;
  logic          ser_dat = 1'b0;
  logic [DW-1:0] load_value;
  logic          load_valid;
  logic          load_ready = 1'b1;
  logic          err_frame;

  prog_load_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_cs_n  (ser_cs_n),
    .ser_clk   (ser_clk),
    .ser_dat   (ser_dat),
    .load_value(load_value),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int vld_cyc = 0;
  logic [DW-1:0] xq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_frame) err_cnt++;
      if (load_valid) vld_cyc++;
      if (load_valid && load_ready) xq.push_back(load_value);
    end
  end

  typedef struct {
    logic [7:0] data;
    int         adj;
    int         exp_xfer;
    logic [7:0] exp_val;
    int         exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] frame(logic [7:0] d);
`ifdef PROG_LOAD_PARITY_EN
    return {7'b0, d, ^d};
`else
    return {8'b0, d};
`endif
  endfunction

  task automatic shift_bits(logic [15:0] b, int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_dat = b[i];
      tick(3);
      ser_clk = 1'b1;
      tick(4);
      ser_clk = 1'b0;
      tick(3);
    end
  endtask

  task automatic cs_low();
    ser_cs_n = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    ser_cs_n = 1'b1;
    tick(10);
  endtask

  task automatic clear();
    err_cnt = 0;
    vld_cyc = 0;
    xq.delete();
  endtask

  task automatic send(logic [15:0] b, int n);
    cs_low();
    shift_bits(b, n);
    cs_high();
  endtask

  initial begin
    tbl[0] = '{8'hA5, 0, 1, 8'hA5, 0};
    tbl[1] = '{8'h3C, 0, 1, 8'h3C, 0};
    tbl[2] = '{8'h00, 0, 1, 8'h00, 0};
    tbl[3] = '{8'hFF, 0, 1, 8'hFF, 0};
    tbl[4] = '{8'h12, -1, 0, 8'hFF, 1};
    tbl[5] = '{8'h34, 1, 0, 8'hFF, 1};
    tbl[6] = '{8'h56, 3, 0, 8'hFF, 1};
    tbl[7] = '{8'h78, -FB, 0, 8'hFF, 1};
    tbl[8] = '{8'h81, 0, 1, 8'h81, 0};

    tick(3);
    chk("rst_valid", 32'(load_valid), 32'd0);
    chk("rst_value", 32'(load_value), 32'd0);
    chk("rst_err", 32'(err_frame), 32'd0);
    rst_n = 1'b1;
    tick(5);

    foreach (tbl[i]) begin
      clear();
      send(frame(tbl[i].data), FB + tbl[i].adj);
      chk($sformatf("v%0d_xfer", i), 32'(xq.size()),
          32'(tbl[i].exp_xfer));
      if (xq.size() > 0)
        chk($sformatf("v%0d_word", i), 32'(xq[0]),
            32'(tbl[i].exp_val));
      chk($sformatf("v%0d_vcyc", i), 32'(vld_cyc),
          32'(tbl[i].exp_xfer));
      chk($sformatf("v%0d_err", i), 32'(err_cnt),
          32'(tbl[i].exp_err));
      chk($sformatf("v%0d_value", i), 32'(load_value),
          32'(tbl[i].exp_val));
    end

    // latency from cs_n rising edge to load_valid
    clear();
    cs_low();
    shift_bits(frame(8'hA5), FB);
    ser_cs_n = 1'b1;
    for (int k = 1; k <= SS + 2; k++) begin
      @(posedge clk);
      #1;
      if (k == SS + 1) chk("lat_early", 32'(load_valid), 32'd0);
      if (k == SS + 2) begin
        chk("lat_valid", 32'(load_valid), 32'd1);
        chk("lat_value", 32'(load_value), 32'hA5);
      end
    end
    tick(1);
    chk("lat_drop", 32'(load_valid), 32'd0);
    tick(8);
    chk("lat_err", 32'(err_cnt), 32'd0);

    // backpressure: second frame in HOLD is dropped
    load_ready = 1'b0;
    clear();
    send(frame(8'h3C), FB);
    chk("bp_valid", 32'(load_valid), 32'd1);
    chk("bp_value", 32'(load_value), 32'h3C);
    send(frame(8'hFF), FB);
    chk("bp_err", 32'(err_cnt), 32'd1);
    chk("bp_valid2", 32'(load_valid), 32'd1);
    chk("bp_value2", 32'(load_value), 32'h3C);
    chk("bp_noxfer", 32'(xq.size()), 32'd0);
    load_ready = 1'b1;
    tick(3);
    chk("bp_xfer", 32'(xq.size()), 32'd1);
    if (xq.size() > 0) chk("bp_word", 32'(xq[0]), 32'h3C);
    chk("bp_idle", 32'(load_valid), 32'd0);
    chk("bp_err2", 32'(err_cnt), 32'd1);

    // reset in the middle of a frame
    clear();
    cs_low();
    shift_bits(16'h000F, 4);
    rst_n = 1'b0;
    #3;
    chk("mr_value", 32'(load_value), 32'd0);
    chk("mr_valid", 32'(load_valid), 32'd0);
    chk("mr_err", 32'(err_frame), 32'd0);
    ser_cs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    chk("mr_noerr", 32'(err_cnt), 32'd0);
    chk("mr_nov", 32'(vld_cyc), 32'd0);
    send(frame(8'h01), FB);
    chk("mr_xfer", 32'(xq.size()), 32'd1);
    if (xq.size() > 0) chk("mr_word", 32'(xq[0]), 32'h01);
    chk("mr_err2", 32'(err_cnt), 32'd0);

    // cs_fall strobe lands on the handshake cycle
    load_ready = 1'b0;
    clear();
    send(frame(8'h11), FB);
    chk("hs_hold", 32'(load_valid), 32'd1);
    ser_cs_n = 1'b0;
    tick(SS + 1);
    load_ready = 1'b1;
    tick(1);
    chk("hs_left", 32'(load_valid), 32'd0);
    shift_bits(frame(8'h5A), FB);
    cs_high();
    chk("hs_xfer", 32'(xq.size()), 32'd2);
    if (xq.size() > 1) begin
      chk("hs_word0", 32'(xq[0]), 32'h11);
      chk("hs_word1", 32'(xq[1]), 32'h5A);
    end
    chk("hs_err", 32'(err_cnt), 32'd0);

`ifdef PROG_LOAD_PARITY_EN
    clear();
    send({7'b0, 8'h03, 1'b0}, FB);
    chk("par_ok_xfer", 32'(xq.size()), 32'd1);
    if (xq.size() > 0) chk("par_ok_word", 32'(xq[0]), 32'h03);
    chk("par_ok_err", 32'(err_cnt), 32'd0);
    clear();
    send({7'b0, 8'h03, 1'b1}, FB);
    chk("par_bad_xfer", 32'(xq.size()), 32'd0);
    chk("par_bad_vcyc", 32'(vld_cyc), 32'd0);
    chk("par_bad_err", 32'(err_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_load_rx.md
PROG_LOAD_RX -- requirements
Module: prog_load_rx

Interface
REQ-001 Parameter DATA_W, default 8, shall set the width of the load word delivered to the counter.
REQ-002 Parameter SYNC_STAGES, default 2, range 2..3, shall set the flop depth of each serial-pin synchronizer.
REQ-003 Port clk, input, 1: the single system clock, rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port ser_cs_n, input, 1: asynchronous frame select, active low.
REQ-006 Port ser_clk, input, 1: asynchronous serial bit clock; data is sampled on its rising edge.
REQ-007 Port ser_dat, input, 1: asynchronous serial data, MSB first.
REQ-008 Port load_value, output, DATA_W: received word, stable while load_valid is high.
REQ-009 Port load_valid, output, 1: word available to the downstream counter.
REQ-010 Port load_ready, input, 1: counter accepts the word; transfer occurs when load_valid and load_ready are both high on a clk edge.
REQ-011 Port err_frame, output, 1: one-cycle pulse for each discarded frame.

Function
REQ-012 Each of the three serial pins shall pass through its own SYNC_STAGES-flop synchronizer before any use.
REQ-013 Edge detectors on the synchronized signals shall produce single-cycle cs_fall, cs_rise and sclk_rise strobes.
REQ-014 FSM states: IDLE, SHIFT, HOLD.
REQ-015 IDLE -> SHIFT on cs_fall; the bit counter shall clear and the shift register shall clear to 0.
REQ-016 In SHIFT, each sclk_rise while cs is low shall shift the synchronized ser_dat into the LSB and increment a saturating bit counter.
REQ-017 In SHIFT, cs_rise with bit count exactly equal to FRAME_BITS shall register the data word into load_value and move to HOLD.
REQ-018 In SHIFT, cs_rise with any other bit count, short or long, shall pulse err_frame for one cycle, return to IDLE, and leave load_value unchanged.
REQ-019 load_valid shall be high exactly while in HOLD, asserting on the cycle after the qualifying cs_rise strobe.
REQ-020 HOLD -> IDLE on the handshake cycle; the next frame may begin on that same cycle's cs_fall strobe, which shall be honoured.
REQ-021 A frame whose cs_fall arrives while in HOLD shall be ignored entirely; its cs_rise shall pulse err_frame once, and load_value/load_valid shall be unaffected.
REQ-022 sclk_rise outside SHIFT shall have no effect.
REQ-023 cs_fall and cs_rise in the same cycle cannot occur; a cs_rise in IDLE shall have no effect.
REQ-024 Pin-to-load_valid latency shall be SYNC_STAGES+2 clk cycles from the rising edge of ser_cs_n.

Reset
REQ-025 While rst_n is low: state shall be IDLE, load_value 0, load_valid 0, err_frame 0, bit counter 0, shift register 0, and all synchronizer flops 1 for cs_n and 0 for clk/dat.
REQ-026 Reset mid-frame or in HOLD shall discard the frame without any err_frame pulse.
REQ-027 After reset release, the first frame shall be recognised only on a cs_fall strobe.

Configuration
REQ-028 When PROG_LOAD_PARITY_EN is defined, FRAME_BITS shall be DATA_W+1 and the last bit shall be even parity over the data bits; a parity mismatch at a correct-length cs_rise shall pulse err_frame and return to IDLE.
REQ-029 When PROG_LOAD_PARITY_EN is undefined, FRAME_BITS shall be DATA_W, with no parity logic.

Structure
REQ-030 A shared package prog_load_pkg shall hold the FSM state enum (IDLE/SHIFT/HOLD) and the default DATA_W and SYNC_STAGES constants.
REQ-031 The synchronizer shall be a sub-module sync_bit, parameterised by stage count and reset value, instantiated three times.

Verification
REQ-032 Scenario: frame 8'hA5 with load_ready=1 -> load_valid high for one cycle at SYNC_STAGES+2 cycles after cs_n rises, load_value=8'hA5, err_frame=0.
REQ-033 Scenario: load_ready=0 with a 8'h3C frame -> load_valid stays high and load_value=8'h3C holds; a second frame 8'hFF is sent -> one err_frame pulse, and load_value stays 8'h3C until ready.
REQ-034 Scenario: 7-bit frame, then 9-bit frame (parity off) -> one err_frame pulse each, load_valid never asserts.
REQ-035 Scenario: rst_n pulsed low after 4 bits of a frame -> all outputs 0, no err_frame; the next full frame 8'h01 is delivered correctly.
REQ-036 Scenario: PROG_LOAD_PARITY_EN defined -> 8'h03 with parity bit 0 is accepted; 8'h03 with parity bit 1 gives an err_frame pulse and no load_valid.
REQ-037 Scenario: cs_n falls on the same cycle the handshake completes -> that frame 8'h5A is received and delivered.
